// File: rtl/bg_mon_pkg.sv
// Shared types, widths and helpers for the bandgap trim-code monitor.
package bg_mon_pkg;

    localparam int unsigned CODE_W    = 16;
    localparam int unsigned CAP_CNT_W = 8;
    localparam int unsigned MATCH_W   = 4;   // holds LOCK_COUNT up to 15

    typedef enum logic {
        RD_IDLE,
        RD_SHIFT
    } rd_state_t;

    // Controller trim code as captured: coarse in the upper byte.
    typedef struct packed {
        logic [7:0] coarse;
        logic [7:0] fine;
    } trim_code_t;

    // Unsigned |a - b| with one extra bit so no difference can overflow.
    function automatic logic [CODE_W:0] code_absdiff(input logic [CODE_W-1:0] a,
                                                     input logic [CODE_W-1:0] b);
        logic [CODE_W:0] ea;
        logic [CODE_W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

endpackage

// File: rtl/bg_mon_shift.sv
// 16-bit load/shift serializer for the code readout port.
// Ports: clk, reset (async, active-high), rd_req (start pulse),
//        load_data (word captured on an accepted rd_req),
//        rd_busy / sdo_en (transfer in progress), sdo (serial data, MSB first).
module bg_mon_shift
    import bg_mon_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [CODE_W-1:0] load_data,
    output logic              rd_busy,
    output logic              sdo,
    output logic              sdo_en
);

    rd_state_t         state;
    logic [CODE_W-1:0] shreg;
    logic [3:0]        bit_cnt;

    // Outputs are registered from the shift state, so they trail the state by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RD_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            rd_busy <= 1'b0;
            sdo     <= 1'b0;
            sdo_en  <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    rd_busy <= 1'b0;
                    sdo     <= 1'b0;
                    sdo_en  <= 1'b0;
                    if (rd_req) begin
                        shreg   <= load_data;
                        bit_cnt <= 4'd15;
                        state   <= RD_SHIFT;
                    end
                end
                RD_SHIFT: begin
                    rd_busy <= 1'b1;
                    sdo     <= shreg[CODE_W-1];
                    sdo_en  <= 1'b1;
                    shreg   <= {shreg[CODE_W-2:0], 1'b0};
                    if (bit_cnt == 4'd0) begin
                        state <= RD_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bg_code_monitor.sv
// Bandgap trim-code monitor: captures {coarse, fine} on each valid rising edge,
// declares lock after LOCK_COUNT consecutive in-tolerance captures, flags lost
// lock and a stalled controller, and serializes the latest code on request.
// Ports: clk, reset (async, active-high), valid, code_coarse, code_fine,
//        clr (clears sticky flags), rd_req (start readout),
//        code_q, capture_cnt, locked, lost_lock, timeout, sdo, sdo_en, rd_busy.
module bg_code_monitor
    import bg_mon_pkg::*;
#(
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TOL            = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [7:0]           code_coarse,
    input  logic [7:0]           code_fine,
    input  logic                 clr,
    input  logic                 rd_req,
    output logic [CODE_W-1:0]    code_q,
    output logic [CAP_CNT_W-1:0] capture_cnt,
    output logic                 locked,
    output logic                 lost_lock,
    output logic                 timeout,
    output logic                 sdo,
    output logic                 sdo_en,
    output logic                 rd_busy
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]    TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_PRE = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [MATCH_W-1:0] LOCK_V = MATCH_W'(LOCK_COUNT);
    localparam logic [CODE_W:0]    TOL_V  = (CODE_W + 1)'(TOL);

    logic               valid_d;
    logic               have_prev;
    logic [MATCH_W-1:0] match_cnt;
    logic [TO_W-1:0]    to_cnt;

    trim_code_t         new_code;
    logic               cap;
    logic               is_match;
    logic               mismatch;
    logic [MATCH_W-1:0] match_nxt;
    logic               to_set;
    logic               ll_set;

    assign new_code  = {code_coarse, code_fine};
    assign cap       = valid & ~valid_d;
    assign is_match  = code_absdiff(new_code, code_q) <= TOL_V;
    assign mismatch  = cap & have_prev & ~is_match;
    assign match_nxt = (match_cnt == LOCK_V) ? LOCK_V : match_cnt + 4'd1;
    // Timeout fires once, on the edge the counter reaches its saturation value.
    assign to_set    = ~cap & (to_cnt == TO_PRE);
    assign ll_set    = locked & (mismatch | to_set);

    // Capture, match/lock tracking and stall detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_d     <= 1'b0;
            have_prev   <= 1'b0;
            match_cnt   <= '0;
            to_cnt      <= '0;
            code_q      <= '0;
            capture_cnt <= '0;
            locked      <= 1'b0;
            lost_lock   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            valid_d <= valid;
            if (cap) begin
                code_q      <= new_code;
                capture_cnt <= capture_cnt + 8'd1;
                have_prev   <= 1'b1;
                to_cnt      <= '0;
                if (!have_prev) begin
                    match_cnt <= '0;
                end else if (is_match) begin
                    match_cnt <= match_nxt;
                    locked    <= (match_nxt == LOCK_V);
                end else begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TO_W'(1);
                if (to_set) begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end
            end
            // Sticky flags: a set event on the same edge as clr wins.
            timeout   <= to_set | (timeout & ~clr);
            lost_lock <= ll_set | (lost_lock & ~clr);
        end
    end

    // Readout samples code_q before any same-edge capture updates it.
    bg_mon_shift u_shift (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .load_data (code_q),
        .rd_busy   (rd_busy),
        .sdo       (sdo),
        .sdo_en    (sdo_en)
    );

endmodule

// File: tb/tb_bg_code_monitor.sv
// Directed self-checking bench for bg_code_monitor (TIMEOUT_CYCLES = 16).
module tb_bg_code_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  code_coarse = 8'h00;
    logic [7:0]  code_fine = 8'h00;
    logic        clr = 1'b0;
    logic        rd_req = 1'b0;
    logic [15:0] code_q;
    logic [7:0]  capture_cnt;
    logic        locked;
    logic        lost_lock;
    logic        timeout;
    logic        sdo;
    logic        sdo_en;
    logic        rd_busy;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  exp_cnt = 8'h00;

    bg_code_monitor #(
        .LOCK_COUNT     (4),
        .TOL            (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .code_coarse (code_coarse),
        .code_fine   (code_fine),
        .clr         (clr),
        .rd_req      (rd_req),
        .code_q      (code_q),
        .capture_cnt (capture_cnt),
        .locked      (locked),
        .lost_lock   (lost_lock),
        .timeout     (timeout),
        .sdo         (sdo),
        .sdo_en      (sdo_en),
        .rd_busy     (rd_busy)
    );

    always #50 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid with a new code; returns just after the capture edge.
    task automatic cap_start(input logic [15:0] c);
        valid = 1'b1;
        {code_coarse, code_fine} = c;
        tick();
        exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic drop();
        valid = 1'b0;
        tick();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({code_q, capture_cnt, locked, lost_lock, timeout, sdo, sdo_en, rd_busy} !== 30'd0)
            $display("FAIL reset_init: outputs=%h required 0",
                     {code_q, capture_cnt, locked, lost_lock, timeout, sdo, sdo_en, rd_busy});
        else n_pass++;
        reset = 1'b0;
        cap_start(16'hF111);
        drop();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if (sdo_en !== 1'b1 || sdo !== 1'b1)
            $display("FAIL reset_pre_shift: sdo_en=%b sdo=%b required 1 1", sdo_en, sdo);
        else n_pass++;
        #20 reset = 1'b1;
        #1;
        n_checks++;
        if ({code_q, capture_cnt, locked, lost_lock, timeout, sdo, sdo_en, rd_busy} !== 30'd0)
            $display("FAIL reset_async: outputs=%h required 0",
                     {code_q, capture_cnt, locked, lost_lock, timeout, sdo, sdo_en, rd_busy});
        else n_pass++;
        tick();
        reset = 1'b0;
        exp_cnt = 8'h00;
        {code_coarse, code_fine} = 16'h5555;
        tick();
        tick();
        tick();
        n_checks++;
        if (capture_cnt !== 8'd0 || code_q !== 16'h0000)
            $display("FAIL reset_no_capture: capture_cnt=%0d code_q=%h required 0 0000",
                     capture_cnt, code_q);
        else n_pass++;
    endtask

    task automatic test_lock();
        for (int i = 1; i <= 5; i++) begin
            cap_start(16'h8040);
            n_checks++;
            if (locked !== (i == 5) || capture_cnt !== exp_cnt)
                $display("FAIL lock_cap%0d: locked=%b cnt=%0d required %b %0d",
                         i, locked, capture_cnt, (i == 5), exp_cnt);
            else n_pass++;
            tick();
            n_checks++;
            if (capture_cnt !== exp_cnt)
                $display("FAIL lock_hold%0d: capture_cnt=%0d required %0d", i, capture_cnt, exp_cnt);
            else n_pass++;
            drop();
        end
        n_checks++;
        if (code_q !== 16'h8040 || capture_cnt !== 8'd5)
            $display("FAIL lock_final: code_q=%h cnt=%0d required 8040 5", code_q, capture_cnt);
        else n_pass++;
    endtask

    task automatic test_lost_lock();
        cap_start(16'h8042);
        n_checks++;
        if (locked !== 1'b0 || lost_lock !== 1'b1)
            $display("FAIL lost_mismatch: locked=%b lost_lock=%b required 0 1", locked, lost_lock);
        else n_pass++;
        drop();
        pulse_clr();
        n_checks++;
        if (lost_lock !== 1'b0)
            $display("FAIL lost_clr: lost_lock=%b required 0", lost_lock);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cap_start(16'h8042);
            drop();
        end
        n_checks++;
        if (locked !== 1'b1)
            $display("FAIL lost_relock: locked=%b required 1", locked);
        else n_pass++;
        clr = 1'b1;
        cap_start(16'h8000);
        clr = 1'b0;
        n_checks++;
        if (lost_lock !== 1'b1 || locked !== 1'b0)
            $display("FAIL lost_clr_vs_set: lost_lock=%b locked=%b required 1 0", lost_lock, locked);
        else n_pass++;
        drop();
        pulse_clr();
        n_checks++;
        if (lost_lock !== 1'b0 || timeout !== 1'b0)
            $display("FAIL lost_clr2: lost_lock=%b timeout=%b required 0 0", lost_lock, timeout);
        else n_pass++;
    endtask

    task automatic test_tolerance();
        logic [15:0] seq [5];
        seq = '{16'h80FF, 16'h8100, 16'h80FF, 16'h8100, 16'h80FF};
        for (int i = 0; i < 5; i++) begin
            cap_start(seq[i]);
            n_checks++;
            if (locked !== (i == 4) || lost_lock !== 1'b0)
                $display("FAIL tol_cap%0d: locked=%b lost_lock=%b required %b 0",
                         i, locked, lost_lock, (i == 4));
            else n_pass++;
            drop();
        end
    endtask

    task automatic test_timeout();
        cap_start(16'h8100);
        valid = 1'b0;
        for (int i = 1; i <= 14; i++) tick();
        n_checks++;
        if (timeout !== 1'b0 || locked !== 1'b1)
            $display("FAIL to_edge14: timeout=%b locked=%b required 0 1", timeout, locked);
        else n_pass++;
        tick();
        n_checks++;
        if (timeout !== 1'b1 || locked !== 1'b0 || lost_lock !== 1'b1)
            $display("FAIL to_edge15: timeout=%b locked=%b lost_lock=%b required 1 0 1",
                     timeout, locked, lost_lock);
        else n_pass++;
        tick();
        tick();
        tick();
        cap_start(16'h8100);
        n_checks++;
        if (timeout !== 1'b1 || capture_cnt !== exp_cnt)
            $display("FAIL to_after_cap: timeout=%b cnt=%0d required 1 %0d",
                     timeout, capture_cnt, exp_cnt);
        else n_pass++;
        drop();
        pulse_clr();
        n_checks++;
        if (timeout !== 1'b0 || lost_lock !== 1'b0)
            $display("FAIL to_clr: timeout=%b lost_lock=%b required 0 0", timeout, lost_lock);
        else n_pass++;
    endtask

    task automatic test_readout();
        logic [15:0] pat;
        pat = 16'hA55A;
        cap_start(16'hA55A);
        drop();
        valid = 1'b1;
        {code_coarse, code_fine} = 16'h1234;
        rd_req = 1'b1;
        tick();
        exp_cnt = exp_cnt + 8'd1;
        rd_req = 1'b0;
        valid = 1'b0;
        n_checks++;
        if (code_q !== 16'h1234 || sdo_en !== 1'b0 || rd_busy !== 1'b0 || sdo !== 1'b0)
            $display("FAIL rd_start: code_q=%h sdo_en=%b rd_busy=%b sdo=%b required 1234 0 0 0",
                     code_q, sdo_en, rd_busy, sdo);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) begin
                valid = 1'b1;
                {code_coarse, code_fine} = 16'h0F0F;
            end
            if (k == 4) valid = 1'b0;
            if (k == 5) rd_req = 1'b1;
            tick();
            if (k == 3) exp_cnt = exp_cnt + 8'd1;
            rd_req = 1'b0;
            n_checks++;
            if (sdo_en !== 1'b1 || rd_busy !== 1'b1 || sdo !== pat[15-k])
                $display("FAIL rd_bit%0d: sdo_en=%b rd_busy=%b sdo=%b required 1 1 %b",
                         15 - k, sdo_en, rd_busy, sdo, pat[15-k]);
            else n_pass++;
        end
        n_checks++;
        if (code_q !== 16'h0F0F || capture_cnt !== exp_cnt)
            $display("FAIL rd_cap_during_shift: code_q=%h cnt=%0d required 0f0f %0d",
                     code_q, capture_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        pat = 16'h0F0F;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        n_checks++;
        if (sdo_en !== 1'b0 || rd_busy !== 1'b0 || sdo !== 1'b0)
            $display("FAIL b2b_gap: sdo_en=%b rd_busy=%b sdo=%b required 0 0 0", sdo_en, rd_busy, sdo);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_checks++;
            if (sdo_en !== 1'b1 || rd_busy !== 1'b1 || sdo !== pat[15-k])
                $display("FAIL b2b_bit%0d: sdo_en=%b rd_busy=%b sdo=%b required 1 1 %b",
                         15 - k, sdo_en, rd_busy, sdo, pat[15-k]);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (sdo_en !== 1'b0 || rd_busy !== 1'b0 || sdo !== 1'b0)
            $display("FAIL b2b_end: sdo_en=%b rd_busy=%b sdo=%b required 0 0 0", sdo_en, rd_busy, sdo);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_lost_lock();
        test_tolerance();
        test_timeout();
        test_readout();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bg_code_monitor.md
# bg_code_monitor

Monitors the 16-bit trim code produced by the bandgap digital controller. It captures {coarse, fine} on each rising edge of the controller's `valid`, tracks consecutive stable conversions to declare lock, and flags lost lock and a stalled controller (no `valid` within a timeout). A serial readout port shifts the latest captured code to the test/debug interface. It sits directly downstream of the bandgap controller, in the same 10 MHz clock domain.

## Interface
- `LOCK_COUNT`, default 4: consecutive matching captures required for lock (1..15).
- `TOL`, default 1: maximum unsigned |new − prev| on the 16-bit code that still counts as a match.
- `TIMEOUT_CYCLES`, default 4096: clk cycles without a `valid` rising edge before `timeout` is raised (≥2).
- `clk`  in  1  system clock, 10 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `valid`  in  1  controller output-valid level, synchronous to clk, high ≥1 cycle per conversion.
- `code_coarse`  in  8  controller coarse IDAC code.
- `code_fine`  in  8  controller fine IDAC code.
- `clr`  in  1  one-cycle pulse that clears sticky flags `lost_lock` and `timeout`.
- `rd_req`  in  1  one-cycle pulse that starts a serial readout.
- `code_q`  out  16  last captured {coarse, fine}.
- `capture_cnt`  out  8  number of captures, wraps 255→0.
- `locked`  out  1  code stable for LOCK_COUNT matches.
- `lost_lock`  out  1  sticky; set when a locked monitor sees a mismatch or timeout.
- `timeout`  out  1  sticky; set on timeout.
- `sdo`  out  1  serial data, MSB first.
- `sdo_en`  out  1  high while `sdo` carries valid bits.
- `rd_busy`  out  1  readout in progress.

## Operation
- **Reset:** all outputs and internal registers are 0, including `valid_d`, `match_cnt`, `have_prev`, the timeout counter and the shift state.
- **Capture:** a capture happens at a clk edge where `valid`=1 and `valid_d`=0. At that edge:
  - `code_q` <= {code_coarse, code_fine}
  - `capture_cnt` += 1
  - `have_prev` <= 1
  - the timeout counter is cleared
- **Match:** evaluated on the 17-bit absolute difference between the new code and `code_q`. A difference ≤ TOL is a match. No comparison is made on the first capture after reset (`have_prev`=0); that capture leaves `match_cnt` at 0.
- **On a match:** `match_cnt` increments, saturating at LOCK_COUNT. `locked` is set at the same edge on which `match_cnt` becomes LOCK_COUNT.
- **On a mismatch:** `match_cnt` <= 0 and `locked` <= 0. If `locked` was 1, `lost_lock` <= 1.
- **Timeout:** the counter increments every cycle with no capture and saturates at TIMEOUT_CYCLES−1. On reaching that value:
  - `timeout` <= 1, `locked` <= 0, `match_cnt` <= 0
  - `lost_lock` <= 1 if `locked` was 1
  - it stays saturated until the next capture; that capture clears the counter but not the flag.
- **Sticky-flag clear:** `clr` clears `lost_lock` and `timeout`. If `clr` coincides with a set event, set wins.
- **Readout FSM:**
  - IDLE: `rd_req` loads the shift register with the current `code_q` (the value before any same-edge capture), then goes to SHIFT with bit counter 15.
  - SHIFT: `sdo` = shreg[15] and `sdo_en` = 1. The register shifts left each cycle. After the bit-0 cycle the FSM returns to IDLE.
  - `rd_req` while in SHIFT is ignored.
  - Captures during SHIFT do not alter the shifted data.
  - `sdo` = 0 whenever `sdo_en` = 0.

## Timing
- `code_q`, `capture_cnt`, `locked`, `lost_lock` and `timeout` change at the first clk edge where `valid` is sampled high after being low. Latency is one cycle from `valid` rising to visible outputs.
- `valid` held high for several cycles gives exactly one capture. A new capture requires `valid` to go low for ≥1 cycle.
- Readout: `rd_req` sampled at edge t. `sdo_en`/`rd_busy` are high from t+1 through t+16, with bits 15..0 presented in that order. `rd_busy` falls at edge t+17. A new `rd_req` is accepted from edge t+17.
- Reset mid-readout aborts the transfer immediately: `sdo_en`, `rd_busy` and `sdo` go to 0 asynchronously.

## Structure
- Package `bg_mon_pkg`:
  - readout state enum {RD_IDLE, RD_SHIFT}
  - `CODE_W`=16 and `CAP_CNT_W`=8
  - helper function `code_absdiff(a, b)` returning 17 bits
- Sub-module `bg_mon_shift`: the 16-bit load/shift serializer with `rd_req`/`rd_busy`/`sdo`/`sdo_en`, instantiated once.
- The top level holds edge detection, match/lock logic and the timeout counter.

## Test plan
- **Reset:** assert `reset` mid-operation → all outputs 0 on the same cycle. After release, no capture occurs until `valid` toggles low→high.
- **Lock:** 5 conversions, each with `valid` high 2 cycles, all code 0x8040 → `locked`=0 after captures 1–4, `locked`=1 one cycle after capture 5. `capture_cnt`=5.
- **Lost lock:** while locked, capture 0x8042 (diff 2) → `locked`=0, `lost_lock`=1. Next `clr` → `lost_lock`=0. Simultaneous `clr` and a mismatch while locked → `lost_lock` stays 1.
- **Tolerance:** captures 0x80FF, 0x8100, 0x80FF alternating (diff 1), LOCK_COUNT+1 captures → `locked`=1.
- **Timeout:** set TIMEOUT_CYCLES=16. While locked, stop `valid` → `timeout`=1, `locked`=0, `lost_lock`=1 exactly 15 cycles after the last capture edge. Next capture leaves `timeout`=1.
- **Readout:** `code_q`=0xA55A, pulse `rd_req` on the same edge as a capture of 0x1234 → `sdo` sequence 1010010101011010 over 16 cycles. A second `rd_req` mid-shift is ignored. `code_q`=0x1234 afterwards.
